// File: rtl/code2_fetch_if.sv
// Fetch-stage bundle: instruction-memory read port, decode handshake and redirect.
// The master modport is the fetch stage; the slave modport is memory/decode/redirect.
interface code2_fetch_if #(
    parameter int I = 24,
    parameter int P = 16
) ();
    logic         imem_req_o;
    logic [P-1:0] imem_addr_o;
    logic [I-1:0] imem_rdata_i;
    logic         valid_o;
    logic         ready_i;
    logic [I-1:0] instr_o;
    logic [P-1:0] next_pc_o;
    logic         redirect_i;
    logic [P-1:0] redirect_pc_i;

    modport master (
        output imem_req_o, imem_addr_o, valid_o, instr_o, next_pc_o,
        input  imem_rdata_i, ready_i, redirect_i, redirect_pc_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, valid_o, instr_o, next_pc_o,
        output imem_rdata_i, ready_i, redirect_i, redirect_pc_i
    );
endinterface

// File: rtl/code2_fetch.sv
// code2 fetch stage: PC, one-cycle-latency imem reads and a DEPTH-entry prefetch FIFO.
// Define CODE2_FETCH_PERF_EN to add the fetch_cnt_o / bubble_cnt_o counters.
module code2_fetch #(
    parameter int           I         = 24,
    parameter int           P         = 16,
    parameter int           DEPTH     = 2,
    parameter logic [P-1:0] RESET_PC  = '0,
    parameter logic [I-1:0] NOP_INSTR = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    code2_fetch_if.master fif
`ifdef CODE2_FETCH_PERF_EN
    ,
    output logic [31:0]   fetch_cnt_o,
    output logic [31:0]   bubble_cnt_o
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [P-1:0]  pc_p0;
    logic          vld_p1;
    logic [P-1:0]  npc_p1;
    logic [I-1:0]  instr_mem [DEPTH];
    logic [P-1:0]  npc_mem   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          head_vld;
    logic          pop;
    logic          push;
    logic          req;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head_vld  = (count != '0) && !fif.redirect_i;
        pop       = head_vld && fif.ready_i;
        push      = vld_p1 && !fif.redirect_i;
        // occupancy counts the word still in flight so the FIFO can never overflow
        occupancy = {1'b0, count} + (CW+1)'(vld_p1) - (CW+1)'(pop);
        req       = rst_i && !fif.redirect_i && (occupancy < (CW+1)'(DEPTH));
    end

    always_comb begin
        fif.imem_req_o  = req;
        fif.imem_addr_o = pc_p0;
        fif.valid_o     = head_vld;
        fif.instr_o     = head_vld ? instr_mem[rd_ptr] : NOP_INSTR;
        fif.next_pc_o   = head_vld ? npc_mem[rd_ptr] : '0;
    end

    // p0 -> p1: request issue; redirect wins over push, pop and request
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_p0  <= RESET_PC;
            vld_p1 <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (fif.redirect_i) begin
            pc_p0  <= fif.redirect_pc_i;
            vld_p1 <= 1'b0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (req) pc_p0 <= pc_p0 + P'(1);
            vld_p1 <= req;
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // p1 -> FIFO: returned word lands at the tail with the PC+1 captured at issue
    always_ff @(posedge clk_i) begin
        if (req) npc_p1 <= pc_p0 + P'(1);
        if (push) begin
            instr_mem[wr_ptr] <= fif.imem_rdata_i;
            npc_mem[wr_ptr]   <= npc_p1;
        end
    end

`ifdef CODE2_FETCH_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_cnt_o  <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (pop) fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (fif.ready_i && !head_vld) bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_code2_fetch.sv
// Bench for code2_fetch: queue-level reference model checked every cycle, plus
// hand-computed directed expectations; second instance uses RESET_PC=16'hFFFE.
module tb_code2_fetch;
    logic clk;
    logic rst_n;

    code2_fetch_if #(.I(24), .P(16)) bus_a ();
    code2_fetch_if #(.I(24), .P(16)) bus_b ();

`ifdef CODE2_FETCH_PERF_EN
    logic [31:0] fetch_cnt_a, bubble_cnt_a, fetch_cnt_b, bubble_cnt_b;
`endif

    code2_fetch #(.I(24), .P(16), .DEPTH(2), .RESET_PC(16'h0000), .NOP_INSTR(24'h000000)) dut_a (
        .clk_i (clk),
        .rst_i (rst_n),
        .fif   (bus_a)
`ifdef CODE2_FETCH_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_a),
        .bubble_cnt_o (bubble_cnt_a)
`endif
    );

    code2_fetch #(.I(24), .P(16), .DEPTH(2), .RESET_PC(16'hFFFE), .NOP_INSTR(24'h000000)) dut_b (
        .clk_i (clk),
        .rst_i (rst_n),
        .fif   (bus_b)
`ifdef CODE2_FETCH_PERF_EN
        ,
        .fetch_cnt_o  (fetch_cnt_b),
        .bubble_cnt_o (bubble_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] mem_word(input logic [15:0] a);
        return {8'h00, a} ^ 24'hA50000;
    endfunction

    // Reference model for instance A: FIFO as a queue of fetched addresses
    localparam int DEPTH_A = 2;
    logic [15:0] q [$];
    logic        m_infl;
    logic [15:0] m_infl_addr;
    logic [15:0] m_pc;
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;

    always @(negedge clk) begin : model
        logic        e_valid;
        logic        e_pop;
        logic        e_req;
        logic [15:0] head;
        int          occ;
        if (!rst_n) begin
            q.delete();
            m_infl      = 1'b0;
            m_infl_addr = 16'h0;
            m_pc        = 16'h0000;
            m_fetch     = 32'd0;
            m_bubble    = 32'd0;
        end
        head    = (q.size() != 0) ? q[0] : 16'h0;
        e_valid = (q.size() != 0) && !bus_a.redirect_i;
        e_pop   = e_valid && bus_a.ready_i;
        occ     = q.size() + (m_infl ? 1 : 0) - (e_pop ? 1 : 0);
        e_req   = rst_n && !bus_a.redirect_i && (occ < DEPTH_A);
        chk("model_valid",   bus_a.valid_o,     e_valid);
        chk("model_instr",   bus_a.instr_o,     e_valid ? mem_word(head) : 24'h0);
        chk("model_next_pc", bus_a.next_pc_o,   e_valid ? 16'(head + 16'd1) : 16'h0);
        chk("model_req",     bus_a.imem_req_o,  e_req);
        chk("model_addr",    bus_a.imem_addr_o, m_pc);
`ifdef CODE2_FETCH_PERF_EN
        chk("model_fetch_cnt",  fetch_cnt_a,  m_fetch);
        chk("model_bubble_cnt", bubble_cnt_a, m_bubble);
`endif
        if (rst_n) begin
            if (e_pop) m_fetch = m_fetch + 32'd1;
            if (bus_a.ready_i && !e_valid) m_bubble = m_bubble + 32'd1;
            if (bus_a.redirect_i) begin
                q.delete();
                m_infl = 1'b0;
                m_pc   = bus_a.redirect_pc_i;
            end else begin
                if (e_pop) void'(q.pop_front());
                if (m_infl) q.push_back(m_infl_addr);
                m_infl      = e_req;
                m_infl_addr = m_pc;
                if (e_req) m_pc = m_pc + 16'd1;
            end
        end
    end

    // Memory responder state: request seen in the previous cycle
    logic        seen_req_a, seen_req_b;
    logic [15:0] seen_addr_a, seen_addr_b;

    task automatic step(input logic r, input logic rdy, input logic rd, input logic [15:0] rpc);
        @(posedge clk);
        #1;
        rst_n                = r;
        bus_a.imem_rdata_i   = seen_req_a ? mem_word(seen_addr_a) : 24'hBADBAD;
        bus_b.imem_rdata_i   = seen_req_b ? mem_word(seen_addr_b) : 24'hBADBAD;
        bus_a.ready_i        = rdy;
        bus_a.redirect_i     = rd;
        bus_a.redirect_pc_i  = rpc;
        @(negedge clk);
        seen_req_a  = bus_a.imem_req_o;
        seen_addr_a = bus_a.imem_addr_o;
        seen_req_b  = bus_b.imem_req_o;
        seen_addr_b = bus_b.imem_addr_o;
    endtask

    logic [15:0] b_addr_lit [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    logic [15:0] b_npc_lit  [3] = '{16'hFFFF, 16'h0000, 16'h0001};

    initial begin
        rst_n               = 1'b0;
        bus_a.imem_rdata_i  = 24'h0;
        bus_a.ready_i       = 1'b0;
        bus_a.redirect_i    = 1'b0;
        bus_a.redirect_pc_i = 16'h0;
        bus_b.imem_rdata_i  = 24'h0;
        bus_b.ready_i       = 1'b1;
        bus_b.redirect_i    = 1'b0;
        bus_b.redirect_pc_i = 16'h0;
        seen_req_a = 1'b0; seen_addr_a = 16'h0;
        seen_req_b = 1'b0; seen_addr_b = 16'h0;

        repeat (3) step(1'b0, 1'b1, 1'b0, 16'h0);
        chk("reset_valid",   bus_a.valid_o,     1'b0);
        chk("reset_instr",   bus_a.instr_o,     24'h000000);
        chk("reset_next_pc", bus_a.next_pc_o,   16'h0000);
        chk("reset_req",     bus_a.imem_req_o,  1'b0);
        chk("reset_addr_b",  bus_b.imem_addr_o, 16'hFFFE);

        // Cycles 0..11: streaming from address 0
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (k < 3) begin
                chk("start_addr",   bus_a.imem_addr_o, k);
                chk("start_req",    bus_a.imem_req_o,  1'b1);
                chk("wrap_addr_b",  bus_b.imem_addr_o, b_addr_lit[k]);
            end
            if (k >= 2 && k < 5) chk("wrap_next_pc_b", bus_b.next_pc_o, b_npc_lit[k-2]);
            if (k < 2) chk("start_valid", bus_a.valid_o, 1'b0);
            if (k == 2) begin
                chk("first_valid",   bus_a.valid_o,   1'b1);
                chk("first_instr",   bus_a.instr_o,   24'hA50000);
                chk("first_next_pc", bus_a.next_pc_o, 16'h0001);
            end
            if (k == 3) chk("second_instr", bus_a.instr_o, 24'hA50001);
            if (k == 11) chk("stream_instr", bus_a.instr_o, 24'hA50009);
`ifdef CODE2_FETCH_PERF_EN
            if (k == 4) begin
                chk("b_fetch_cnt",  fetch_cnt_b,  32'd2);
                chk("b_bubble_cnt", bubble_cnt_b, 32'd2);
            end
`endif
        end

        // Cycle 12: redirect to 0x0100 mid-stream
        step(1'b1, 1'b0, 1'b1, 16'h0100);
        chk("redir_valid", bus_a.valid_o,    1'b0);
        chk("redir_req",   bus_a.imem_req_o, 1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        chk("redir_addr",  bus_a.imem_addr_o, 16'h0100);
        chk("redir_drop",  bus_a.valid_o,     1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        chk("redir_gap",   bus_a.valid_o,     1'b0);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        chk("redir_valid_t3", bus_a.valid_o,   1'b1);
        chk("redir_instr",    bus_a.instr_o,   24'hA50100);
        chk("redir_next_pc",  bus_a.next_pc_o, 16'h0101);
`ifdef CODE2_FETCH_PERF_EN
        chk("perf_fetch_cnt",  fetch_cnt_a,  32'd10);
        chk("perf_bubble_cnt", bubble_cnt_a, 32'd4);
`endif

        // Cycles 16..19 streaming, 20..24 stall
        repeat (4) step(1'b1, 1'b1, 1'b0, 16'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            chk("stall_instr", bus_a.instr_o,    24'hA50105);
            chk("stall_req",   bus_a.imem_req_o, 1'b0);
        end

        // Cycles 25..29 resume: no loss, no duplicate
        step(1'b1, 1'b1, 1'b0, 16'h0);
        chk("resume_instr0", bus_a.instr_o, 24'hA50105);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        chk("resume_instr1", bus_a.instr_o, 24'hA50106);
        step(1'b1, 1'b1, 1'b0, 16'h0);
        chk("resume_instr2", bus_a.instr_o, 24'hA50107);
        repeat (2) step(1'b1, 1'b1, 1'b0, 16'h0);

        // Cycles 30..33 stall until full, then asynchronous reset mid-cycle
        repeat (4) step(1'b1, 1'b0, 1'b0, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus_a.valid_o,     1'b0);
        chk("async_rst_instr", bus_a.instr_o,     24'h000000);
        chk("async_rst_npc",   bus_a.next_pc_o,   16'h0000);
        chk("async_rst_req",   bus_a.imem_req_o,  1'b0);
        chk("async_rst_addr",  bus_a.imem_addr_o, 16'h0000);
        repeat (2) step(1'b0, 1'b1, 1'b0, 16'h0);

        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0);
            if (k == 0) chk("restart_addr", bus_a.imem_addr_o, 16'h0000);
            if (k == 2) begin
                chk("restart_valid", bus_a.valid_o, 1'b1);
                chk("restart_instr", bus_a.instr_o, 24'hA50000);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
